// File: rtl/median_pkg.sv
// Shared types and defaults for the median-filter window buffer logic.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    WAIT     = 2'd2,
    SEND_REQ = 2'd3
  } state_t;

  localparam int DEF_FILL_LEN = 9;

  // Bit width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fill_buf_ctrl_if.sv
// Fill-side handshake bundle: control/read/send strobes in, buffer bookkeeping out.
interface fill_buf_ctrl_if
  import median_pkg::*;
#(
  parameter int NBUF     = 2,
  parameter int FILL_LEN = DEF_FILL_LEN
);

  localparam int CNT_W = width_of(FILL_LEN);
  localparam int IDX_W = width_of(NBUF);

  logic             start;
  logic             flush;
  logic             rd_ack;
  logic             send_busy;
  logic             send_done;
  logic             rd_req;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] wr_addr;
  logic             send_req;
  logic [IDX_W-1:0] send_idx;
  logic             filling;
  logic             no_free;
  logic [IDX_W:0]   occ_cnt;
  logic             err;

  // master is the fill controller, slave is the surrounding sampler/memory/sender.
  modport master (
    input  start, flush, rd_ack, send_busy, send_done,
    output rd_req, wr_idx, wr_addr, send_req, send_idx, filling, no_free, occ_cnt, err
  );

  modport slave (
    output start, flush, rd_ack, send_busy, send_done,
    input  rd_req, wr_idx, wr_addr, send_req, send_idx, filling, no_free, occ_cnt, err
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear (priority) and count enable.
module mod_counter #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/fill_buf_ctrl.sv
// Fill controller for NBUF rotating window buffers: allocates, fills FILL_LEN words, hands off to sender.
module fill_buf_ctrl
  import median_pkg::*;
#(
  parameter int NBUF     = 2,
  parameter int FILL_LEN = DEF_FILL_LEN
) (
  input logic             clk,
  input logic             rst_n,
  fill_buf_ctrl_if.master bus
);

  localparam int CNT_W = width_of(FILL_LEN);
  localparam int IDX_W = width_of(NBUF);
  localparam logic [IDX_W:0]   NBUF_C    = (IDX_W + 1)'(NBUF);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(FILL_LEN - 1);

  state_t           state, state_nxt;
  logic             pend;
  logic             err_q;
  logic [IDX_W:0]   occ_cnt;
  logic [CNT_W-1:0] wr_addr;
  logic [IDX_W-1:0] wr_idx;
  logic             release_ok, alloc, fill_last;

  assign release_ok = bus.send_done && (occ_cnt != '0);
  // A release in the same cycle frees a slot for this allocation.
  assign alloc      = (state == IDLE) && (bus.start || pend) && !bus.flush &&
                      ((occ_cnt != NBUF_C) || release_ok);
  assign fill_last  = (state == READ) && bus.rd_ack && (wr_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (alloc) state_nxt = READ;
        READ:     if (fill_last) state_nxt = bus.send_busy ? WAIT : SEND_REQ;
        WAIT:     if (!bus.send_busy) state_nxt = SEND_REQ;
        SEND_REQ: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      occ_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (bus.send_done && (occ_cnt == '0)) err_q <= 1'b1;
      if (bus.flush) begin
        pend    <= 1'b0;
        occ_cnt <= '0;
      end else begin
        pend    <= alloc ? 1'b0 : (bus.start || pend);
        occ_cnt <= occ_cnt + (IDX_W + 1)'(alloc) - (IDX_W + 1)'(release_ok);
      end
    end
  end

  mod_counter #(.MOD(FILL_LEN), .W(CNT_W)) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush || (state == IDLE)),
    .en    ((state == READ) && bus.rd_ack),
    .cnt   (wr_addr)
  );

  // Buffer index advances as the filled buffer is handed over.
  mod_counter #(.MOD(NBUF), .W(IDX_W)) u_idx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .en    (state == SEND_REQ),
    .cnt   (wr_idx)
  );

  assign bus.rd_req   = (state == READ);
  assign bus.filling  = (state != IDLE);
  assign bus.send_req = (state == SEND_REQ);
  assign bus.send_idx = wr_idx;
  assign bus.wr_idx   = wr_idx;
  assign bus.wr_addr  = wr_addr;
  assign bus.occ_cnt  = occ_cnt;
  assign bus.no_free  = (occ_cnt == NBUF_C);
  assign bus.err      = err_q;

endmodule

// File: doc/fill_buf_ctrl.md
Name: fill_buf_ctrl

Overview:
- Fill-side controller for the median-filter window buffers.
- Generalises the single-buffer fill FSM to NBUF rotating temp buffers with a FILL_LEN-word fill counter, read handshake, pending-start latch, flush and occupancy tracking.
- Sits between the control sampler / memory read port and the send logic. It lets the next window be filled while earlier windows are still being sent.

Parameters:
- NBUF, 2, number of temp buffers in rotation (≥1).
- FILL_LEN, 9, words per fill (3x3 window).
- CNT_W, $clog2(FILL_LEN), width of word address (minimum 1).
- IDX_W, $clog2(NBUF), buffer index width (minimum 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  control data sampled; request a new fill (1-cycle pulse).
- flush  in  1  synchronous abort; clears all state.
- rd_ack  in  1  read word valid this cycle (handshake with rd_req).
- send_busy  in  1  send logic is sending.
- send_done  in  1  send logic released its oldest buffer (1-cycle pulse).
- rd_req  out  1  read request; high throughout READ.
- wr_idx  out  IDX_W  buffer currently being filled.
- wr_addr  out  CNT_W  word address within wr_idx for the current rd_ack.
- send_req  out  1  1-cycle pulse: buffer send_idx is full and may be sent.
- send_idx  out  IDX_W  buffer handed to the sender with send_req.
- filling  out  1  high when state != IDLE.
- no_free  out  1  all NBUF buffers occupied.
- occ_cnt  out  IDX_W+1  buffers allocated and not yet released.
- err  out  1  sticky: send_done received with occ_cnt==0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - Outputs rd_req, send_req, filling, err, wr_idx, wr_addr, send_idx, occ_cnt all 0.
  - no_free = 0; pend = 0.
- States: IDLE, READ, WAIT, SEND_REQ. Encoding is 2 bits; IDLE = 0.
- pend register:
  - Set by start when start is not consumed this cycle.
  - Cleared when consumed or on flush.
- IDLE:
  - If (start | pend) and occ_cnt < NBUF: go to READ and allocate buffer wr_idx (occ_cnt += 1).
  - Clear wr_addr and pend.
- READ:
  - rd_req = 1.
  - Each rd_ack: the word is written to wr_addr, then wr_addr increments.
  - rd_ack with wr_addr == FILL_LEN-1 completes the fill. Go to WAIT if send_busy, else SEND_REQ.
  - No rd_ack: stay in READ; gaps of any length are legal.
- WAIT: stay while send_busy; otherwise go to SEND_REQ.
- SEND_REQ:
  - send_req = 1 for exactly one cycle; send_idx = wr_idx.
  - Next cycle: wr_idx ← (wr_idx + 1) mod NBUF, state ← IDLE.
- Latency:
  - Last rd_ack to send_req is 1 cycle when the sender is idle.
  - start in IDLE with a free buffer raises rd_req the next cycle.
  - Back-to-back fills have a 1-cycle IDLE gap minimum (pend makes this automatic).
- Release:
  - send_done decrements occ_cnt.
  - Buffers are released in FIFO order; the sender owns ordering.
  - send_done with occ_cnt == 0 is ignored and sets err.
- Simultaneous events:
  - Allocation and send_done in the same cycle: occ_cnt is unchanged; the allocation succeeds even if occ_cnt == NBUF before the cycle (the release counts first).
  - start while filling/WAIT/SEND_REQ, or in IDLE with no free buffer: latched in pend. A second start while pend = 1 is dropped.
- flush:
  - Highest priority below reset.
  - Next cycle: state IDLE, occ_cnt 0, wr_idx 0, wr_addr 0, pend 0, send_req 0.
  - err is unchanged (cleared only by reset).
- no_free is combinational: (occ_cnt == NBUF).
- wr_addr never exceeds FILL_LEN-1; wr_idx wraps at NBUF, which need not be a power of 2.

Decomposition:
- Shared package median_pkg holds:
  - state typedef/localparams (IDLE, READ, WAIT, SEND_REQ);
  - default FILL_LEN (9).
- One natural sub-module, mod_counter (parametrised modulo-N counter with clear and enable).
  - Instantiated twice: for wr_addr (mod FILL_LEN) and wr_idx (mod NBUF).

Test Plan:
- Single fill, NBUF=2, FILL_LEN=9, sender idle:
  - start pulse → rd_req high the next cycle.
  - 9 consecutive rd_ack → send_req pulse 1 cycle after the 9th, with send_idx=0.
  - Then IDLE; occ_cnt=1; wr_idx=1.
- Busy sender: send_busy held high for 5 cycles after the fill completes → stays in WAIT; send_req is asserted 1 cycle after send_busy falls.
- Full rotation: 3 start pulses with no send_done, NBUF=2:
  - Two fills complete (send_idx 0 then 1); no_free=1.
  - Third start is held in pend and rd_req stays low.
  - send_done → the third fill begins next cycle in buffer 0.
- Gapped reads: rd_ack on alternate cycles → wr_addr sequence 0..8; send_req only after the 9th ack.
- Flush mid-READ after 4 acks → next cycle IDLE, rd_req=0, occ_cnt=0, wr_addr=0, no send_req.
- Error and corner cases:
  - send_done with occ_cnt=0 → err=1 and stays set until reset.
  - Allocation and send_done in the same cycle at occ_cnt=2 → occ_cnt stays 2.
  - rst_n asserted mid-WAIT → all outputs 0 immediately.
